// File: rtl/pixel_shade.sv
// Depth shader: pops one nearest-hit record, turns its squared distance from the
// origin into an 8-bit grey level and writes it at the next raster position.
// p_hit packs three signed D_BITS lanes: x in the low lane, then y, then z on top.
module pixel_shade #(
  parameter int unsigned Q_BITS      = 10,
  parameter int unsigned D_BITS      = 32,
  parameter int unsigned M_BITS      = 12,
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned DEPTH_SHIFT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  input  logic                       hit,
  input  logic [3*D_BITS-1:0]        p_hit,
  input  logic [M_BITS-1:0]          triangle_ID,
  input  logic                       out_full,
  output logic                       out_wr_en,
  output logic [$clog2(IMG_W)-1:0]   pixel_x,
  output logic [$clog2(IMG_H)-1:0]   pixel_y,
  output logic [7:0]                 pixel_val,
  output logic                       frame_done
);

  localparam int unsigned XW  = $clog2(IMG_W);
  localparam int unsigned YW  = $clog2(IMG_H);
  localparam int unsigned PW  = 2 * D_BITS;
  localparam int unsigned SQW = 2 * D_BITS - Q_BITS;
  localparam int unsigned D2W = SQW + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    SUM    = 3'd2,
    SHADE  = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                      hit_r;
  logic [3*D_BITS-1:0]       p_r;
  logic [M_BITS-1:0]         tri_r;
  logic [SQW-1:0]            sq_r [3];
  logic [D2W-1:0]            d2_r;

  logic signed [D_BITS-1:0]  lane     [3];
  logic signed [PW-1:0]      lane_ext [3];
  logic signed [PW-1:0]      lane_sq  [3];
  logic [SQW-1:0]            lane_sh  [3];
  logic [D2W-1:0]            d2_sum;
  logic [D2W-1:0]            t;
  logic [7:0]                shade_val;
  logic                      last_x;
  logic                      last_y;
  logic                      unused_capture;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO handshakes; reads are suppressed while reset is held
  always_comb begin
    state_nxt = IDLE;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
        if (!in_empty && reset) begin
          in_rd_en  = 1'b1;
          state_nxt = hit ? SQUARE : WRITE;
        end
      end
      SQUARE: state_nxt = SUM;
      SUM:    state_nxt = SHADE;
      SHADE:  state_nxt = WRITE;
      WRITE: begin
        if (out_full) begin
          state_nxt = WRITE;
        end else begin
          out_wr_en = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-axis square at full signed width, rescaled by the fraction bits
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lane[i]     = p_r[i*D_BITS +: D_BITS];
      lane_ext[i] = {{D_BITS{lane[i][D_BITS-1]}}, lane[i]};
      lane_sq[i]  = lane_ext[i] * lane_ext[i];
      lane_sh[i]  = SQW'(lane_sq[i] >>> Q_BITS);
    end
  end

  assign d2_sum    = D2W'(sq_r[0]) + D2W'(sq_r[1]) + D2W'(sq_r[2]);
  assign t         = d2_r >> DEPTH_SHIFT;
  // Far hits clamp to 1 so a hit is never confused with background 0
  assign shade_val = (t >= D2W'(254)) ? 8'd1 : 8'(D2W'(255) - t);

  assign last_x     = (pixel_x == XW'(IMG_W - 1));
  assign last_y     = (pixel_y == YW'(IMG_H - 1));
  assign frame_done = out_wr_en && last_x && last_y;

  // Captured for completeness; shading does not depend on these
  assign unused_capture = hit_r ^ (^tri_r);

  // Datapath and raster position
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_r     <= 1'b0;
      p_r       <= '0;
      tri_r     <= '0;
      for (int i = 0; i < 3; i++) sq_r[i] <= '0;
      d2_r      <= '0;
      pixel_val <= '0;
      pixel_x   <= '0;
      pixel_y   <= '0;
    end else begin
      if (in_rd_en) begin
        hit_r <= hit;
        p_r   <= p_hit;
        tri_r <= triangle_ID;
        if (!hit) pixel_val <= '0;
      end
      if (state == SQUARE) begin
        for (int i = 0; i < 3; i++) sq_r[i] <= lane_sh[i];
      end
      if (state == SUM)   d2_r      <= d2_sum;
      if (state == SHADE) pixel_val <= shade_val;
      if (out_wr_en) begin
        if (last_x) begin
          pixel_x <= '0;
          pixel_y <= last_y ? '0 : pixel_y + YW'(1);
        end else begin
          pixel_x <= pixel_x + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_shade.sv
// Scoreboard bench for pixel_shade: a FIFO-like source feeds records, expected
// pixels are queued at each read and popped by a monitor at every write.
module tb_pixel_shade;

  localparam int unsigned Q_BITS      = 10;
  localparam int unsigned D_BITS      = 32;
  localparam int unsigned M_BITS      = 12;
  localparam int unsigned IMG_W       = 4;
  localparam int unsigned IMG_H       = 2;
  localparam int unsigned DEPTH_SHIFT = 4;
  localparam int unsigned XW          = $clog2(IMG_W);
  localparam int unsigned YW          = $clog2(IMG_H);

  logic                  clock;
  logic                  reset;
  logic                  in_empty;
  logic                  in_rd_en;
  logic                  hit;
  logic [3*D_BITS-1:0]   p_hit;
  logic [M_BITS-1:0]     triangle_ID;
  logic                  out_full;
  logic                  out_wr_en;
  logic [XW-1:0]         pixel_x;
  logic [YW-1:0]         pixel_y;
  logic [7:0]            pixel_val;
  logic                  frame_done;

  pixel_shade #(
    .Q_BITS(Q_BITS), .D_BITS(D_BITS), .M_BITS(M_BITS),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH_SHIFT(DEPTH_SHIFT)
  ) dut (
    .clock(clock), .reset(reset),
    .in_empty(in_empty), .in_rd_en(in_rd_en),
    .hit(hit), .p_hit(p_hit), .triangle_ID(triangle_ID),
    .out_full(out_full), .out_wr_en(out_wr_en),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_val(pixel_val), .frame_done(frame_done)
  );

  typedef struct { bit h; int x; int y; int z; int val; } rec_t;
  typedef struct { int px; int py; int val; bit fd; int cap; int lat; bit chk; } exp_t;

  rec_t src[$];
  exp_t sb[$];
  rec_t mon_r;
  exp_t mon_e;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ncap = 0;
  int exp_idx = 0;
  bit toggle_mode = 0;
  bit rand_full = 0;
  bit force_full = 0;
  bit gate = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference shading straight from the distance rule, in 64-bit arithmetic
  function automatic int model_val(rec_t r);
    longint q;
    longint d2;
    longint tt;
    if (!r.h) return 0;
    q  = longint'(1) << Q_BITS;
    d2 = (longint'(r.x) * r.x) / q + (longint'(r.y) * r.y) / q + (longint'(r.z) * r.z) / q;
    tt = d2 / (longint'(1) << DEPTH_SHIFT);
    return (tt >= 254) ? 1 : int'(255 - tt);
  endfunction

  task automatic push(bit h, int x, int y, int z, int val);
    rec_t r;
    r.h = h; r.x = x; r.y = y; r.z = z; r.val = val;
    src.push_back(r);
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Upstream FIFO head and downstream backpressure, updated just after each edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      gate = ~gate;
      if (src.size() != 0 && (!toggle_mode || gate)) begin
        in_empty = 1'b0;
        hit      = src[0].h;
        p_hit    = {D_BITS'(src[0].z), D_BITS'(src[0].y), D_BITS'(src[0].x)};
      end else begin
        in_empty = 1'b1;
        hit      = 1'($urandom);
        p_hit    = {$urandom, $urandom, $urandom};
      end
      triangle_ID = M_BITS'($urandom);
      out_full    = force_full || (rand_full && ($urandom_range(0, 1) == 1));
    end
  end

  // Monitor: reads push expectations, writes pop and compare
  always @(negedge clock) begin
    if (in_rd_en) begin
      check("read_while_empty", in_empty, 0);
      check("rd_wr_overlap", out_wr_en, 0);
      if (src.size() == 0) begin
        check("read_without_record", src.size(), 1);
      end else begin
        mon_r     = src.pop_front();
        mon_e.val = (mon_r.val >= 0) ? mon_r.val : model_val(mon_r);
        mon_e.px  = exp_idx % IMG_W;
        mon_e.py  = (exp_idx / IMG_W) % IMG_H;
        mon_e.fd  = (exp_idx % (IMG_W * IMG_H)) == (IMG_W * IMG_H - 1);
        mon_e.cap = cyc;
        mon_e.lat = mon_r.h ? 4 : 1;
        mon_e.chk = !rand_full && !force_full;
        sb.push_back(mon_e);
        exp_idx++;
        ncap++;
      end
    end
    if (out_wr_en) begin
      check("write_while_full", out_full, 0);
      if (sb.size() == 0) begin
        check("write_without_record", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("pixel_x", pixel_x, mon_e.px);
        check("pixel_y", pixel_y, mon_e.py);
        check("pixel_val", pixel_val, mon_e.val);
        check("frame_done", frame_done, mon_e.fd);
        if (mon_e.chk) check("latency", cyc - mon_e.cap, mon_e.lat);
      end
    end
    if (frame_done && !out_wr_en) check("frame_done_without_write", out_wr_en, 1);
  end

  task automatic drain(int budget);
    int n = 0;
    while ((src.size() != 0 || sb.size() != 0) && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("drain_outstanding", src.size() + sb.size(), 0);
  endtask

  task automatic wait_cap(int n0, int budget);
    int n = 0;
    while (ncap == n0 && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("capture_seen", ncap - n0, 1);
  endtask

  initial begin
    int n0;
    reset       = 1'b0;
    in_empty    = 1'b1;
    hit         = 1'b0;
    p_hit       = '0;
    triangle_ID = '0;
    out_full    = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixel_val", pixel_val, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_y", pixel_y, 0);
    reset = 1'b1;

    // Known shading values and a full frame wrap
    push(1, 1024, 0, 0, 191);
    push(0, 777, -3, 99999, 0);
    push(1, 0, 0, 0, 255);
    push(1, -32768, 0, 0, 1);
    push(0, -5, 12, 0, 0);
    push(1, -1024, 0, 0, 191);
    push(1, 512, 512, 512, 207);
    push(0, 1, 2, 3, 0);
    push(1, 0, 32768, 0, 1);
    drain(2000);

    // Downstream held full: no write, no further read, held pixel intact
    force_full = 1'b1;
    n0 = ncap;
    push(1, 0, 0, 0, 255);
    push(0, 5, 5, 5, 0);
    wait_cap(n0, 100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #2;
      check("stall_no_write", out_wr_en, 0);
      check("stall_no_read", in_rd_en, 0);
    end
    if (sb.size() == 0) begin
      check("stall_pending_record", sb.size(), 1);
    end else begin
      check("stall_pixel_val", pixel_val, sb[0].val);
      check("stall_pixel_x", pixel_x, sb[0].px);
      check("stall_pixel_y", pixel_y, sb[0].py);
    end
    force_full = 1'b0;
    drain(2000);

    // Reset while the record sits in SUM
    n0 = ncap;
    push(1, 1024, 0, 0, 191);
    wait_cap(n0, 100);
    push(1, 1024, 0, 0, 191);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_in_rd_en", in_rd_en, 0);
    check("midrst_out_wr_en", out_wr_en, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_pixel_val", pixel_val, 0);
    check("midrst_pixel_x", pixel_x, 0);
    check("midrst_pixel_y", pixel_y, 0);
    sb.delete();
    exp_idx = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drain(2000);

    // Random records with toggling input availability and random backpressure
    toggle_mode = 1'b1;
    rand_full   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(($urandom_range(0, 3) != 0), rnd_coord(), rnd_coord(), rnd_coord(), -1);
    end
    drain(30000);
    toggle_mode = 1'b0;
    rand_full   = 1'b0;
    repeat (10) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
